cmd_responder: RTL and testbench

Card-side CMD line responder: the far end of the host CMD driver on the single-bit SD CMD line. It receives a 48-bit host command, checks start, transmission and end bits and CRC7, and presents index and argument to the card model logic. On request it transmits an R1/R3 48-bit or R2 136-bit response. It sits in the SD card model and loopback test harness, sharing the `iclk` domain with the host driver.

---
 rtl/sd_pkg.sv | 41 ++++
 rtl/crc7.sv | 32 +++
 rtl/cmd_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_cmd_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_pkg : shared SD CMD-line encodings, frame geometry and CRC7 step
// Rev 1.0
// ---------------------------------------------------------------------------
package sd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_RCV_CMD   = 4'd1,
      ST_RCV_CRC   = 4'd2,
      ST_RCV_END   = 4'd3,
      ST_WAIT_APP  = 4'd4,
      ST_NCR_WAIT  = 4'd5,
      ST_SEND_RESP = 4'd6,
      ST_SEND_CRC  = 4'd7,
      ST_SEND_END  = 4'd8
   } rsp_state_e;

   localparam logic [1:0] c_resp_none = 2'd0;
   localparam logic [1:0] c_resp_r1   = 2'd1;
   localparam logic [1:0] c_resp_r3   = 2'd2;
   localparam logic [1:0] c_resp_r2   = 2'd3;

   localparam int c_cmd_frame_len = 48;
   localparam int c_r2_frame_len  = 136;
   localparam int c_pay_r1        = 38;
   localparam int c_pay_r2        = 133;
   localparam int c_crc_len       = 7;

   // x^7 + x^3 + 1, implicit x^7 term
   localparam logic [6:0] c_crc7_poly = 7'h09;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? c_crc7_poly : 7'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// crc7 : serial CRC7 engine; shifts data in, or unloads the remainder MSB first
// Rev 1.0
// ---------------------------------------------------------------------------
module crc7
   import sd_pkg::*;
(
   input  logic iclk,
   input  logic irst,
   input  logic ien,
   input  logic iunload,
   input  logic idata,
   output logic ocrc
);

   logic [6:0] r_crc;

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_crc <= '0;
      end else if (iunload) begin
         r_crc <= {r_crc[5:0], 1'b0};
      end else if (ien) begin
         r_crc <= crc7_step(r_crc, idata);
      end
   end

   assign ocrc = r_crc[6];

endmodule
`default_nettype wire

// File: rtl/cmd_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_responder : card-side SD CMD line receiver / R1,R2,R3 response transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
module cmd_responder
   import sd_pkg::*;
#(
   parameter int NCR = 2
)(
   input  logic         irst,
   input  logic         iclk,
   input  logic         icmd_sd,
   output logic         ocmd_sd_en,
   output logic         ocmd_sd,
   output logic         ocmd_valid,
   output logic [5:0]   ocmd_index,
   output logic [31:0]  ocmd_arg,
   output logic         oerr_crc,
   output logic         oerr_frame,
   input  logic         irespond,
   input  logic [1:0]   iresp_type,
   input  logic [132:0] iresp,
   output logic         odone
);

   localparam logic [7:0] c_cnt_cmd      = 8'(c_cmd_frame_len - c_crc_len - 3);
   localparam logic [7:0] c_cnt_crc      = 8'(c_crc_len - 1);
   localparam logic [7:0] c_cnt_tx_short = 8'(c_cmd_frame_len - c_crc_len - 2);
   localparam logic [7:0] c_cnt_tx_long  = 8'(c_r2_frame_len - 2);
   localparam logic [7:0] c_cnt_ncr      = 8'(NCR - 1);
   localparam int         c_tx_w         = c_pay_r2 + 2;

   rsp_state_e          r_state;
   rsp_state_e          w_state_nxt;
   logic [7:0]          r_cnt;
   logic [38:0]         r_rx_shift;
   logic                r_crc_bad;
   logic [5:0]          r_index;
   logic [31:0]         r_arg;
   logic                r_err_crc;
   logic                r_err_frame;
   logic                r_done;
   logic [1:0]          r_resp_type;
   logic [c_tx_w-1:0]   r_tx_shift;

   logic                w_crc_clr;
   logic                w_crc_en;
   logic                w_crc_unload;
   logic                w_crc_data;
   logic                w_crc_out;
   logic                w_cnt_zero;
   logic                w_tx_bit;
   logic                w_frame_bad;
   logic                w_sd_en;
   logic                w_sd;

   assign w_cnt_zero  = (r_cnt == 8'd0);
   assign w_tx_bit    = r_tx_shift[c_tx_w-1];
   assign w_frame_bad = ~icmd_sd | ~r_rx_shift[38];

   // The clear is state-derived, so it also covers the reset state (IDLE).
   crc7 u_crc7 (
      .iclk    (iclk),
      .irst    (w_crc_clr),
      .ien     (w_crc_en),
      .iunload (w_crc_unload),
      .idata   (w_crc_data),
      .ocrc    (w_crc_out)
   );

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_crc_clr    = 1'b0;
      w_crc_en     = 1'b0;
      w_crc_unload = 1'b0;
      w_crc_data   = icmd_sd;
      w_sd_en      = 1'b0;
      w_sd         = 1'b1;
      unique case (r_state)
         ST_IDLE: begin
            // start bit 0 leaves a cleared CRC at zero, so clearing here is exact
            w_crc_clr = 1'b1;
            if (!icmd_sd) w_state_nxt = ST_RCV_CMD;
         end
         ST_RCV_CMD: begin
            w_crc_en = 1'b1;
            if (w_cnt_zero) w_state_nxt = ST_RCV_CRC;
         end
         ST_RCV_CRC: begin
            w_crc_unload = 1'b1;
            if (w_cnt_zero) w_state_nxt = ST_RCV_END;
         end
         ST_RCV_END: begin
            if (w_frame_bad || r_crc_bad) w_state_nxt = ST_IDLE;
            else                          w_state_nxt = ST_WAIT_APP;
         end
         ST_WAIT_APP: begin
            w_crc_clr = 1'b1;
            if (irespond) begin
               if (iresp_type == c_resp_none) w_state_nxt = ST_IDLE;
               else                           w_state_nxt = ST_NCR_WAIT;
            end
         end
         ST_NCR_WAIT: begin
            if (w_cnt_zero) w_state_nxt = ST_SEND_RESP;
         end
         ST_SEND_RESP: begin
            w_sd_en    = 1'b1;
            w_sd       = w_tx_bit;
            w_crc_en   = 1'b1;
            w_crc_data = w_tx_bit;
            if (w_cnt_zero) begin
               // R2 carries its own CRC inside the CID/CSD payload
               if (r_resp_type == c_resp_r2) w_state_nxt = ST_SEND_END;
               else                          w_state_nxt = ST_SEND_CRC;
            end
         end
         ST_SEND_CRC: begin
            w_sd_en      = 1'b1;
            w_crc_unload = 1'b1;
            unique case (r_resp_type)
               c_resp_r1: w_sd = w_crc_out;
               c_resp_r3: w_sd = 1'b1;
               default:   w_sd = 1'b1;
            endcase
            if (w_cnt_zero) w_state_nxt = ST_SEND_END;
         end
         ST_SEND_END: begin
            w_sd_en     = 1'b1;
            w_sd        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_cnt       <= '0;
         r_rx_shift  <= '0;
         r_crc_bad   <= 1'b0;
         r_index     <= '0;
         r_arg       <= '0;
         r_err_crc   <= 1'b0;
         r_err_frame <= 1'b0;
         r_done      <= 1'b0;
         r_resp_type <= c_resp_none;
         r_tx_shift  <= '0;
      end else begin
         r_err_crc   <= 1'b0;
         r_err_frame <= 1'b0;
         r_done      <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_cnt     <= c_cnt_cmd;
               r_crc_bad <= 1'b0;
            end
            ST_RCV_CMD: begin
               r_rx_shift <= {r_rx_shift[37:0], icmd_sd};
               r_cnt      <= w_cnt_zero ? c_cnt_crc : r_cnt - 8'd1;
            end
            ST_RCV_CRC: begin
               if (icmd_sd != w_crc_out) r_crc_bad <= 1'b1;
               r_cnt <= r_cnt - 8'd1;
            end
            ST_RCV_END: begin
               if (w_frame_bad) begin
                  r_err_frame <= 1'b1;
               end else if (r_crc_bad) begin
                  r_err_crc <= 1'b1;
               end else begin
                  r_index <= r_rx_shift[37:32];
                  r_arg   <= r_rx_shift[31:0];
               end
            end
            ST_WAIT_APP: begin
               if (irespond) begin
                  r_resp_type <= iresp_type;
                  r_cnt       <= c_cnt_ncr;
                  if (iresp_type == c_resp_r2) begin
                     r_tx_shift <= {2'b00, iresp};
                  end else begin
                     r_tx_shift <= {2'b00, iresp[c_pay_r2-1 -: c_pay_r1],
                                    {(c_pay_r2 - c_pay_r1){1'b0}}};
                  end
                  if (iresp_type == c_resp_none) r_done <= 1'b1;
               end
            end
            ST_NCR_WAIT: begin
               if (w_cnt_zero) begin
                  r_cnt <= (r_resp_type == c_resp_r2) ? c_cnt_tx_long : c_cnt_tx_short;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_SEND_RESP: begin
               r_tx_shift <= {r_tx_shift[c_tx_w-2:0], 1'b0};
               r_cnt      <= w_cnt_zero ? c_cnt_crc : r_cnt - 8'd1;
            end
            ST_SEND_CRC: begin
               r_cnt <= r_cnt - 8'd1;
            end
            ST_SEND_END: begin
               r_done <= 1'b1;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign ocmd_sd_en = w_sd_en;
   assign ocmd_sd    = w_sd;
   assign ocmd_valid = (r_state == ST_WAIT_APP);
   assign ocmd_index = r_index;
   assign ocmd_arg   = r_arg;
   assign oerr_crc   = r_err_crc;
   assign oerr_frame = r_err_frame;
   assign odone      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cmd_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_responder : scoreboard bench with a polynomial-division CRC7 model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmd_responder;

   localparam int NCR = 3;
   localparam int K_CMD = 0, K_ERRC = 1, K_ERRF = 2, K_RESP = 3, K_DONE = 4;

   typedef struct {
      int            kind;
      logic [135:0]  bits;
      int            len;
      int            t;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   logic         irst = 1'b1;
   logic         iclk = 1'b0;
   logic         icmd_sd = 1'b1;
   logic         irespond = 1'b0;
   logic [1:0]   iresp_type = 2'd0;
   logic [132:0] iresp = '0;
   logic         ocmd_sd_en, ocmd_sd, ocmd_valid, oerr_crc, oerr_frame, odone;
   logic [5:0]   ocmd_index;
   logic [31:0]  ocmd_arg;

   cmd_responder #(.NCR(NCR)) dut (
      .irst       (irst),
      .iclk       (iclk),
      .icmd_sd    (icmd_sd),
      .ocmd_sd_en (ocmd_sd_en),
      .ocmd_sd    (ocmd_sd),
      .ocmd_valid (ocmd_valid),
      .ocmd_index (ocmd_index),
      .ocmd_arg   (ocmd_arg),
      .oerr_crc   (oerr_crc),
      .oerr_frame (oerr_frame),
      .irespond   (irespond),
      .iresp_type (iresp_type),
      .iresp      (iresp),
      .odone      (odone)
   );

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1
   function automatic logic [6:0] crc7_of(input logic [135:0] msg, input int n);
      logic [142:0] r;
      r = {msg, 7'b0};
      for (int i = n + 6; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] m;
      m = {2'b01, idx, arg};
      return {m, crc7_of({96'b0, m}, 40), 1'b1};
   endfunction

   task automatic resp_model(input logic [1:0] ty, input logic [132:0] p,
                             output logic [135:0] bits, output int len);
      logic [39:0] m;
      m = {2'b00, p[132:95]};
      case (ty)
         2'd1:    begin bits = {88'b0, m, crc7_of({96'b0, m}, 40), 1'b1}; len = 48;  end
         2'd2:    begin bits = {88'b0, m, 7'h7F, 1'b1};                   len = 48;  end
         2'd3:    begin bits = {2'b00, p, 1'b1};                          len = 136; end
         default: begin bits = '0;                                        len = 0;   end
      endcase
   endtask

   task automatic take(input int kind, input string name, output ev_t e, output bit ok);
      ok = 1'b0;
      e  = '{kind: -1, bits: '0, len: 0, t: 0};
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s actual=event required=none (cycle %0d)", name, cyc);
      end else begin
         e = sb.pop_front();
         chk({"event_kind_", name}, 136'(kind), 136'(e.kind));
         ok = (e.kind == kind);
      end
   endtask

   // Monitor: converts DUT output activity into events and checks them against the queue
   initial begin : monitor
      logic         cap_on;
      logic [135:0] cap;
      int           cap_n, cap_start;
      logic         prev_valid;
      ev_t          e;
      bit           ok;
      cap_on = 1'b0; cap = '0; cap_n = 0; cap_start = 0; prev_valid = 1'b0;
      forever begin
         @(negedge iclk);
         if (irst) begin
            cap_on = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (ocmd_sd_en) begin
               if (!cap_on) begin
                  cap_on = 1'b1; cap = '0; cap_n = 0; cap_start = cyc;
               end
               cap = {cap[134:0], ocmd_sd};
               cap_n++;
            end else if (cap_on) begin
               cap_on = 1'b0;
               take(K_RESP, "resp", e, ok);
               if (ok) begin
                  chk("resp_len",   136'(cap_n),     136'(e.len));
                  chk("resp_bits",  cap,             e.bits);
                  chk("resp_start", 136'(cap_start), 136'(e.t));
               end
            end
            if (ocmd_valid && !prev_valid) begin
               take(K_CMD, "cmd", e, ok);
               if (ok) begin
                  chk("cmd_fields", {98'b0, ocmd_index, ocmd_arg}, e.bits);
                  chk("cmd_time",   136'(cyc), 136'(e.t));
               end
            end
            if (oerr_crc) begin
               take(K_ERRC, "err_crc", e, ok);
               if (ok) chk("err_crc_time", 136'(cyc), 136'(e.t));
            end
            if (oerr_frame) begin
               take(K_ERRF, "err_frame", e, ok);
               if (ok) chk("err_frame_time", 136'(cyc), 136'(e.t));
            end
            if (odone) begin
               take(K_DONE, "done", e, ok);
               if (ok) begin
                  chk("done_time", 136'(cyc), 136'(e.t));
                  chk("done_line_released", 136'(ocmd_sd_en), 136'(0));
               end
            end
            prev_valid = ocmd_valid;
         end
      end
   end

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic wait_empty(input int budget, input string what);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s actual=%0d_pending required=0", what, sb.size());
         sb.delete();
      end
   endtask

   // kind: K_CMD for a good frame, K_ERRC / K_ERRF for a corrupted one
   task automatic send_cmd(input logic [47:0] frame, input int kind,
                           input logic [5:0] idx, input logic [31:0] arg);
      for (int i = 47; i >= 0; i--) begin
         tick();
         icmd_sd = frame[i];
      end
      sb.push_back('{kind: kind, bits: {98'b0, idx, arg}, len: 0, t: cyc + 1});
      tick();
      icmd_sd = 1'b1;
   endtask

   task automatic respond(input logic [1:0] ty, input logic [132:0] p,
                          input logic [135:0] exp_bits, input int exp_len);
      int n, t_done;
      n = 0;
      while (!ocmd_valid && n < 4) begin
         tick();
         n++;
      end
      if (!ocmd_valid) begin
         checks++;
         errors++;
         $display("FAIL timeout_cmd_valid actual=0 required=1");
         sb.delete();
      end else begin
         irespond   = 1'b1;
         iresp_type = ty;
         iresp      = p;
         if (ty == 2'd0) begin
            t_done = cyc + 1;
         end else begin
            sb.push_back('{kind: K_RESP, bits: exp_bits, len: exp_len, t: cyc + NCR + 1});
            t_done = cyc + NCR + 1 + exp_len;
         end
         sb.push_back('{kind: K_DONE, bits: '0, len: 0, t: t_done});
         tick();
         irespond = 1'b0;
         // the line is ignored while the card owns the exchange
         while (cyc < t_done - 1) begin
            icmd_sd = 1'($urandom);
            tick();
         end
         icmd_sd = 1'b1;
      end
      wait_empty(300, "response");
   endtask

   task automatic check_reset();
      chk("rst_sd_en", 136'(ocmd_sd_en), 136'(0));
      chk("rst_sd",    136'(ocmd_sd),    136'(1));
      chk("rst_valid", 136'(ocmd_valid), 136'(0));
      chk("rst_index", 136'(ocmd_index), 136'(0));
      chk("rst_arg",   136'(ocmd_arg),   136'(0));
      chk("rst_errs",  136'({oerr_crc, oerr_frame}), 136'(0));
      chk("rst_done",  136'(odone),      136'(0));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [47:0]  f;
      logic [132:0] p;
      logic [135:0] eb;
      int           el, mode;
      logic [5:0]   idx;
      logic [31:0]  arg;
      logic [1:0]   ty;

      repeat (3) tick();
      check_reset();
      irst = 1'b0;
      repeat (2) tick();

      // CMD0, no response
      send_cmd(48'h400000000095, K_CMD, 6'd0, 32'd0);
      respond(2'd0, '0, '0, 0);

      // CMD55 -> R1
      send_cmd(48'h770000000065, K_CMD, 6'd55, 32'd0);
      respond(2'd1, {38'h3700000120, {95{1'b0}}}, {88'b0, 48'h370000012083}, 48);

      // CMD41 -> R3
      send_cmd(cmd_frame(6'd41, 32'h40FF8000), K_CMD, 6'd41, 32'h40FF8000);
      respond(2'd2, {38'h3F00FF8000, {95{1'b0}}}, {88'b0, 48'h3F00FF8000FF}, 48);

      // CMD8 corrupted: CRC bit, end bit, transmission bit + end bit
      send_cmd(48'h48000001AA87 ^ 48'h8, K_ERRC, 6'd8, 32'h1AA);
      wait_empty(10, "err_crc");
      send_cmd(48'h48000001AA86, K_ERRF, 6'd8, 32'h1AA);
      wait_empty(10, "err_frame");
      send_cmd(48'h08000001AA86, K_ERRF, 6'd8, 32'h1AA);
      wait_empty(10, "err_frame_tx");

      // CMD2 -> R2 all ones
      send_cmd(cmd_frame(6'd2, 32'd0), K_CMD, 6'd2, 32'd0);
      respond(2'd3, {133{1'b1}}, {2'b00, {134{1'b1}}}, 136);

      // reset at bit 20 of a command
      for (int i = 47; i >= 28; i--) begin
         tick();
         icmd_sd = cmd_frame(6'd17, 32'h12345678) >> i;
      end
      tick();
      irst = 1'b1;
      icmd_sd = 1'b1;
      repeat (2) tick();
      check_reset();
      irst = 1'b0;
      tick();
      send_cmd(48'h400000000095, K_CMD, 6'd0, 32'd0);
      respond(2'd0, '0, '0, 0);

      // reset at bit 60 of an R2
      send_cmd(cmd_frame(6'd9, 32'hA5A50000), K_CMD, 6'd9, 32'hA5A50000);
      for (int k = 0; k < 133; k++) p[k] = 1'($urandom);
      resp_model(2'd3, p, eb, el);
      tick();
      irespond = 1'b1; iresp_type = 2'd3; iresp = p;
      sb.push_back('{kind: K_RESP, bits: eb, len: el, t: cyc + NCR + 1});
      tick();
      irespond = 1'b0;
      begin
         int n;
         n = 0;
         while (!ocmd_sd_en && n < 20) begin tick(); n++; end
      end
      repeat (60) tick();
      irst = 1'b1;
      sb.delete();
      repeat (2) tick();
      check_reset();
      irst = 1'b0;
      tick();
      send_cmd(48'h400000000095, K_CMD, 6'd0, 32'd0);
      respond(2'd0, '0, '0, 0);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         idx  = 6'($urandom_range(0, 63));
         arg  = $urandom;
         mode = $urandom_range(0, 6);
         f    = cmd_frame(idx, arg);
         case (mode)
            3: begin f[$urandom_range(1, 7)] ^= 1'b1; send_cmd(f, K_ERRC, idx, arg); end
            4: begin f[0] = 1'b0;                     send_cmd(f, K_ERRF, idx, arg); end
            5: begin f[46] = 1'b0;                    send_cmd(f, K_ERRF, idx, arg); end
            6: begin f[$urandom_range(8, 39)] ^= 1'b1; send_cmd(f, K_ERRC, idx, arg); end
            default: begin
               send_cmd(f, K_CMD, idx, arg);
               ty = 2'($urandom_range(0, 3));
               for (int k = 0; k < 133; k++) p[k] = 1'($urandom);
               resp_model(ty, p, eb, el);
               respond(ty, p, eb, el);
            end
         endcase
         wait_empty(10, "random");
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
